sample_demux: RTL
=================

// Module: sample_demux
// PURPOSE
//   Sequential 1:3 sample router. Sends one signed fixed-point sample stream to
//   one of three filter-path destinations (A, B, C), one frame at a time.
//   Sits between the sample front-end and the three parallel filter chains.
//   Every output is registered. Each channel has its own valid/ready handshake.
// PARAMETERS
//   size       21   sample width in bits; samples pass through bit-exact
//   FRAME_LEN  16   samples per frame; destination is latched once per frame; >=1
//   CNT_W      5    frame counter width; must be >= clog2(FRAME_LEN+1)
// PORTS
//   clk        in   1     system clock, rising edge
//   reset      in   1     asynchronous, active-high
//   entrada    in   size  input sample
//   select     in   2     destination: 00->A, 01->B, 10->C, 11->A
//   start      in   1     marks first sample of a frame (qualified by valid_in)
//   valid_in   in   1     input sample valid
//   ready_in   out  1     input can be accepted (combinational)
//   salida_a   out  size  channel A sample register (likewise salida_b, salida_c)
//   valid_a    out  1     channel A holds a sample (likewise valid_b, valid_c)
//   ready_a    in   1     channel A consumer ready (likewise ready_b, ready_c)
//   frame_done out  1     one-cycle pulse after the last sample of a frame is accepted
//   busy       out  1     1 while in ROUTE
// BEHAVIOUR
//   - Reset (async): salida_*=0, valid_*=0, frame_done=0, state=IDLE, count=0,
//     sel_q=00.
//   - Accept: valid_in & ready_in at a rising clk edge.
//   - Destination d = (state==IDLE) ? decode(select) : sel_q.
//   - Channel x is free when !valid_x | ready_x.
//   - ready_in, IDLE: start ? free(d) : 1. Non-start samples are accepted and
//     discarded.
//   - ready_in, ROUTE: free(sel_q).
//   - Channel register:
//       - Loaded on accept to x: salida_x <= entrada, valid_x <= 1.
//       - valid_x clears on valid_x & ready_x with no load that cycle.
//       - Load and drain in the same cycle: new data, valid_x stays 1.
//   - Latency: 1 clk from accept to valid_x.
//   - Unselected channels keep their data and drain independently.
//   - IDLE + accepted start sample:
//       - sel_q <= decode(select); count <= 1; sample goes to d.
//       - FRAME_LEN==1: stay in IDLE, pulse frame_done.
//       - Otherwise: go to ROUTE.
//   - ROUTE:
//       - select and start are ignored; start=1 is ordinary data, not a restart.
//       - Each accept increments count.
//       - On the FRAME_LEN-th accept: count <= 0, state <= IDLE, frame_done=1
//         in the following cycle.
//   - Back-to-back frames: a start in the first IDLE cycle is accepted with no
//     bubble.
//   - Reset mid-frame drops pending samples and the partial frame.
//   - busy = (state==ROUTE), registered state decode.
// CONFIGURATION
//   DEMUX_STATS_EN defined:
//     - Adds outputs cnt_a, cnt_b, cnt_c (16 bits each).
//     - A counter increments on every load into its channel.
//     - Wraps 0xFFFF -> 0; reset value 0.
//   DEMUX_STATS_EN undefined: no counter ports and no counter logic.
// TESTING
//   1. FRAME_LEN=4, select=01, start with 0x00011,0x00022,0x00033,0x1FFFF,
//      all ready=1 -> salida_b shows the same four samples, each one clk after
//      accept; frame_done pulses once; valid_a=valid_c=0 throughout.
//   2. Same frame; select changes to 10 after sample 1 -> all four samples still
//      go to B; next start with select=10 routes to C.
//   3. Frame to C with ready_c=0 -> first sample held, ready_in=0, stall; raise
//      ready_c -> remaining samples delivered with no loss or duplication.
//   4. select=11 with start -> samples routed to A.
//   5. Non-start samples in IDLE -> ready_in=1, all valid_* stay 0.
//   6. reset raised mid-frame with valid_a=1 -> all outputs 0 immediately,
//      busy=0; next start begins a clean frame.

Source files
------------

// File: rtl/sample_demux_if.sv
// Handshake bundle for sample_demux: one input sample stream, three routed channels.
// With DEMUX_STATS_EN defined the per-channel load counters are carried here too.
interface sample_demux_if #(
    parameter int size = 21
);
    logic [size-1:0] entrada;
    logic [1:0]      select;
    logic            start;
    logic            valid_in;
    logic            ready_in;
    logic [size-1:0] salida_a;
    logic [size-1:0] salida_b;
    logic [size-1:0] salida_c;
    logic            valid_a;
    logic            valid_b;
    logic            valid_c;
    logic            ready_a;
    logic            ready_b;
    logic            ready_c;
    logic            frame_done;
    logic            busy;
`ifdef DEMUX_STATS_EN
    logic [15:0]     cnt_a;
    logic [15:0]     cnt_b;
    logic [15:0]     cnt_c;
`endif

    modport master (
        output entrada, select, start, valid_in, ready_a, ready_b, ready_c,
        input  ready_in, salida_a, salida_b, salida_c, valid_a, valid_b, valid_c,
`ifdef DEMUX_STATS_EN
        input  cnt_a, cnt_b, cnt_c,
`endif
        input  frame_done, busy
    );

    modport slave (
        input  entrada, select, start, valid_in, ready_a, ready_b, ready_c,
        output ready_in, salida_a, salida_b, salida_c, valid_a, valid_b, valid_c,
`ifdef DEMUX_STATS_EN
        output cnt_a, cnt_b, cnt_c,
`endif
        output frame_done, busy
    );
endinterface

// File: rtl/sample_demux.sv
// Sequential 1:3 sample router: one frame of FRAME_LEN samples goes to channel A, B or C.
// Optional per-channel load counters are enabled with DEMUX_STATS_EN.
module sample_demux #(
    parameter int size      = 21,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic          clk,
    input  logic          reset,
    sample_demux_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  count_q;
    logic [1:0]        sel_q;
    logic              frame_done_q;
    logic [2:0]        valid_q;
    logic [size-1:0]   data_q [3];

    logic [1:0]        dest_s;
    logic [2:0]        ready_vec_s;
    logic [2:0]        free_s;
    logic              dest_free_s;
    logic              ready_in_s;
    logic              load_s;
    logic              last_s;
    logic [2:0]        load_vec_s;

    // Channel index: 0=A, 1=B, 2=C; code 11 falls back to A.
    function automatic logic [1:0] decode_sel(input logic [1:0] s);
        case (s)
            2'b01:   return 2'd1;
            2'b10:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Destination, back-pressure and load decode for the current cycle.
    always_comb begin
        ready_vec_s = {bus.ready_c, bus.ready_b, bus.ready_a};
        free_s      = ~valid_q | ready_vec_s;
        if (state_q == IDLE) begin
            dest_s = decode_sel(bus.select);
        end else begin
            dest_s = sel_q;
        end
        case (dest_s)
            2'd1:    dest_free_s = free_s[1];
            2'd2:    dest_free_s = free_s[2];
            default: dest_free_s = free_s[0];
        endcase
        // In IDLE only a start sample needs a slot; anything else is swallowed.
        if (state_q == IDLE) begin
            ready_in_s = bus.start ? dest_free_s : 1'b1;
        end else begin
            ready_in_s = dest_free_s;
        end
        load_s = bus.valid_in & ready_in_s & ((state_q == ROUTE) | bus.start);
        if (state_q == ROUTE) begin
            last_s = (count_q == CNT_W'(FRAME_LEN - 1));
        end else begin
            last_s = (FRAME_LEN == 1);
        end
        load_vec_s = {load_s & (dest_s == 2'd2),
                      load_s & (dest_s == 2'd1),
                      load_s & (dest_s == 2'd0)};
    end

    // Frame FSM: state, sample count, latched destination and frame_done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            sel_q        <= 2'b00;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (load_s) begin
                sel_q <= dest_s;
                if (last_s) begin
                    count_q      <= '0;
                    state_q      <= IDLE;
                    frame_done_q <= 1'b1;
                end else begin
                    count_q <= count_q + CNT_W'(1);
                    state_q <= ROUTE;
                end
            end
        end
    end

    // Single-entry output register per channel; a load wins over a drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load_vec_s[i]) begin
                    data_q[i]  <= bus.entrada;
                    valid_q[i] <= 1'b1;
                end else if (valid_q[i] & ready_vec_s[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX_STATS_EN
    logic [15:0] cnt_q [3];

    // Per-channel load counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load_vec_s[i]) begin
                    cnt_q[i] <= cnt_q[i] + 16'h0001;
                end
            end
        end
    end

    assign bus.cnt_a = cnt_q[0];
    assign bus.cnt_b = cnt_q[1];
    assign bus.cnt_c = cnt_q[2];
`endif

    assign bus.ready_in   = ready_in_s;
    assign bus.salida_a   = data_q[0];
    assign bus.salida_b   = data_q[1];
    assign bus.salida_c   = data_q[2];
    assign bus.valid_a    = valid_q[0];
    assign bus.valid_b    = valid_q[1];
    assign bus.valid_c    = valid_q[2];
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q == ROUTE);
endmodule
